// File: rtl/lcd_timing_pkg.sv
// Shared timing defaults, sync polarities and region-bound helper for the LCD raster generator.
package lcd_timing_pkg;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 41;
  localparam bit DEF_HS_ACT   = 1'b0;
  localparam bit DEF_VS_ACT   = 1'b0;

  typedef struct packed {
    int sync_end;
    int bp_end;
    int act_end;
  } region_t;

  // Regions run SYNC, BP, ACTIVE, FP from position 0; each bound is exclusive.
  function automatic region_t calc_bounds(input int sync_w, input int bp_w, input int act_w);
    region_t r;
    r.sync_end = sync_w;
    r.bp_end   = sync_w + bp_w;
    r.act_end  = sync_w + bp_w + act_w;
    return r;
  endfunction

endpackage

// File: rtl/lcd_axis_cnt.sv
// One raster axis: wrapping position counter with step enable, carry and decode of the
// position it is about to present (so the parent can register aligned outputs).
module lcd_axis_cnt
  import lcd_timing_pkg::*;
#(
  parameter int W    = 11,
  parameter int SYNC = 1,
  parameter int BP   = 1,
  parameter int ACT  = 1,
  parameter int FP   = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         step_i,
  output logic [W-1:0] cnt_d_o,
  output logic         carry_o,
  output logic         sync_d_o,
  output logic         act_d_o,
  output logic [W-1:0] pos_d_o
);

  localparam int      TOTAL = SYNC + BP + ACT + FP;
  localparam region_t B     = calc_bounds(SYNC, BP, ACT);

  logic [W-1:0] cnt_q, cnt_d;

  assign carry_o = (cnt_q == W'(TOTAL - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (step_i) cnt_d = carry_o ? '0 : cnt_q + W'(1);
  end

  // Parked on the last position so the first step lands on 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= W'(TOTAL - 1);
    else         cnt_q <= cnt_d;
  end

  assign cnt_d_o  = cnt_d;
  assign sync_d_o = (cnt_d < W'(B.sync_end));
  assign act_d_o  = (cnt_d >= W'(B.bp_end)) && (cnt_d < W'(B.act_end));
  assign pos_d_o  = cnt_d - W'(B.bp_end);

endmodule

// File: rtl/lcd_timing_gen.sv
// Parametrised LCD/VGA raster timing generator with registered, mutually aligned outputs.
// Optional linear pixel index output oPIX_ADDR enabled by defining LCD_TIMING_PIX_ADDR_EN.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_ACT   = DEF_HS_ACT,
  parameter bit VS_ACT   = DEF_VS_ACT,
  parameter int XW       = 11,
  parameter int YW       = 10
) (
  input  logic          iCLK,
  input  logic          iRST_n,
  input  logic          iEN,
  output logic [XW-1:0] oX_CNT,
  output logic [YW-1:0] oY_CNT,
  output logic          oHS,
  output logic          oVS,
  output logic          oDE,
  output logic [XW-1:0] oPX_X,
  output logic [YW-1:0] oPX_Y,
  output logic          oSOF,
  output logic          oEOL
`ifdef LCD_TIMING_PIX_ADDR_EN
  ,
  output logic [XW+YW-1:0] oPIX_ADDR
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_region
    $error("lcd_timing_gen: every active/porch/sync width must be at least 1");
  end
  if (H_TOTAL > 2**XW || V_TOTAL > 2**YW) begin : g_bad_width
    $error("lcd_timing_gen: raster total does not fit the X/Y counter width");
  end

  logic [XW-1:0] x_d, x_pos_d;
  logic [YW-1:0] y_d, y_pos_d;
  logic          x_carry, y_carry, x_sync_d, y_sync_d, x_act_d, y_act_d;

  lcd_axis_cnt #(.W(XW), .SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACTIVE), .FP(H_FP)) u_x (
    .clk_i(iCLK), .rst_ni(iRST_n), .step_i(iEN),
    .cnt_d_o(x_d), .carry_o(x_carry), .sync_d_o(x_sync_d), .act_d_o(x_act_d), .pos_d_o(x_pos_d)
  );

  lcd_axis_cnt #(.W(YW), .SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACTIVE), .FP(V_FP)) u_y (
    .clk_i(iCLK), .rst_ni(iRST_n), .step_i(iEN & x_carry),
    .cnt_d_o(y_d), .carry_o(y_carry), .sync_d_o(y_sync_d), .act_d_o(y_act_d), .pos_d_o(y_pos_d)
  );

  logic          de_d, sof_d, eol_d, hs_d, vs_d;
  logic [XW-1:0] px_x_d;
  logic [YW-1:0] px_y_d;

  assign de_d   = x_act_d & y_act_d;
  assign sof_d  = x_carry & y_carry;
  assign eol_d  = (x_d == XW'(H_TOTAL - 1));
  assign hs_d   = x_sync_d ? HS_ACT : ~HS_ACT;
  assign vs_d   = y_sync_d ? VS_ACT : ~VS_ACT;
  assign px_x_d = de_d ? x_pos_d : '0;
  assign px_y_d = de_d ? y_pos_d : '0;

  logic [XW-1:0] x_q, px_x_q;
  logic [YW-1:0] y_q, px_y_q;
  logic          hs_q, vs_q, de_q, sof_q, eol_q;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      x_q    <= '0;
      y_q    <= '0;
      hs_q   <= ~HS_ACT;
      vs_q   <= ~VS_ACT;
      de_q   <= 1'b0;
      px_x_q <= '0;
      px_y_q <= '0;
      sof_q  <= 1'b0;
      eol_q  <= 1'b0;
    end else if (iEN) begin
      x_q    <= x_d;
      y_q    <= y_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      px_x_q <= px_x_d;
      px_y_q <= px_y_d;
      sof_q  <= sof_d;
      eol_q  <= eol_d;
    end
  end

  assign oX_CNT = x_q;
  assign oY_CNT = y_q;
  assign oHS    = hs_q;
  assign oVS    = vs_q;
  assign oDE    = de_q;
  assign oPX_X  = px_x_q;
  assign oPX_Y  = px_y_q;
  assign oSOF   = sof_q;
  assign oEOL   = eol_q;

`ifdef LCD_TIMING_PIX_ADDR_EN
  // pix_cnt_q is the index the next active pixel will get; no multiplier needed.
  logic [XW+YW-1:0] pix_cnt_q, pix_addr_q;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      pix_cnt_q  <= '0;
      pix_addr_q <= '0;
    end else if (iEN) begin
      if (sof_d) begin
        pix_cnt_q  <= '0;
        pix_addr_q <= '0;
      end else if (de_d) begin
        pix_addr_q <= pix_cnt_q;
        pix_cnt_q  <= pix_cnt_q + (XW+YW)'(1);
      end
    end
  end

  assign oPIX_ADDR = pix_addr_q;
`endif

endmodule
